// File: rtl/operand_stack_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_stack_ctrl_if
// Brief    : Command/pop/TOS bundle between the execute stage and the stack.
// Revision : 1.0
// ============================================================================
interface operand_stack_ctrl_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 64
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cmd_data;
  logic [1:0]            cmd_type;
  logic                  chk_en;
  logic [1:0]            chk_type;
  logic                  pop_valid;
  logic [WIDTH-1:0]      pop_data;
  logic [1:0]            pop_type;
  logic [WIDTH-1:0]      result;
  logic [1:0]            result_type;
  logic                  result_empty;
  logic [DEPTH_LOG2:0]   count;
  logic [2:0]            trap;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_type, chk_en, chk_type,
    input  cmd_ready, pop_valid, pop_data, pop_type, result, result_type,
           result_empty, count, trap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_type, chk_en, chk_type,
    output cmd_ready, pop_valid, pop_data, pop_type, result, result_type,
           result_empty, count, trap
  );
endinterface
`default_nettype wire

// File: rtl/operand_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : operand_stack_ctrl
// Brief    : Wasm operand stack with TOS register and sync-read RAM below it.
// Revision : 1.0
// ============================================================================
module operand_stack_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 64
) (
  input  wire logic           clk,
  input  wire logic           reset,
  operand_stack_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [1:0]          c_OP_PUSH   = 2'd1;
  localparam logic [1:0]          c_OP_POP    = 2'd2;
  localparam logic [1:0]          c_OP_REPL   = 2'd3;
  localparam logic [2:0]          c_TRAP_NONE = 3'd0;
  localparam logic [2:0]          c_TRAP_UNDR = 3'd1;
  localparam logic [2:0]          c_TRAP_OVFL = 3'd2;
  localparam logic [2:0]          c_TRAP_TYPE = 3'd3;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REFILL = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
  logic [WIDTH-1:0]      r_tos, w_tos_nxt;
  logic [1:0]            r_tos_type, w_tos_type_nxt;
  logic                  r_pop_valid, w_pop_valid_nxt;
  logic [WIDTH-1:0]      r_pop_data, w_pop_data_nxt;
  logic [1:0]            r_pop_type, w_pop_type_nxt;
  logic [2:0]            r_trap, w_trap_nxt;

  logic [WIDTH+1:0]      r_mem [0:DEPTH-2];
  logic [WIDTH+1:0]      r_rdata;
  logic                  w_mem_we, w_mem_re;
  logic [DEPTH_LOG2-1:0] w_wr_addr, w_rd_addr;
  logic                  w_ready, w_accept, w_takes_tos;
  logic [2:0]            w_err;

  assign w_ready     = (r_state == S_IDLE) && (r_trap == c_TRAP_NONE);
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_takes_tos = (bus.cmd_op == c_OP_POP) || (bus.cmd_op == c_OP_REPL);
  // Entry count-1 is the TOS itself, so the RAM holds entries 0..count-2.
  assign w_wr_addr   = DEPTH_LOG2'(r_count - 1'b1);
  assign w_rd_addr   = DEPTH_LOG2'(r_count - 2'd2);

  always_comb begin
    w_err = c_TRAP_NONE;
    if (w_takes_tos && r_count == '0)
      w_err = c_TRAP_UNDR;
    else if (bus.cmd_op == c_OP_PUSH && r_count == c_FULL)
      w_err = c_TRAP_OVFL;
    else if (w_takes_tos && bus.chk_en && r_tos_type != bus.chk_type)
      w_err = c_TRAP_TYPE;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_tos_nxt       = r_tos;
    w_tos_type_nxt  = r_tos_type;
    w_pop_valid_nxt = 1'b0;
    w_pop_data_nxt  = r_pop_data;
    w_pop_type_nxt  = r_pop_type;
    w_trap_nxt      = r_trap;
    w_mem_we        = 1'b0;
    w_mem_re        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err != c_TRAP_NONE) begin
            w_trap_nxt = w_err;
          end else if (bus.cmd_op == c_OP_PUSH) begin
            w_mem_we       = (r_count != '0);
            w_tos_nxt      = bus.cmd_data;
            w_tos_type_nxt = bus.cmd_type;
            w_count_nxt    = r_count + 1'b1;
          end else if (w_takes_tos) begin
            w_pop_valid_nxt = 1'b1;
            w_pop_data_nxt  = r_tos;
            w_pop_type_nxt  = r_tos_type;
            if (bus.cmd_op == c_OP_REPL) begin
              w_tos_nxt      = bus.cmd_data;
              w_tos_type_nxt = bus.cmd_type;
            end else begin
              w_count_nxt = r_count - 1'b1;
              if (r_count == (DEPTH_LOG2+1)'(1)) begin
                w_tos_nxt      = '0;
                w_tos_type_nxt = '0;
              end else begin
                w_mem_re    = 1'b1;
                w_state_nxt = S_REFILL;
              end
            end
          end
        end
      end
      S_REFILL: begin
        w_tos_nxt      = r_rdata[WIDTH-1:0];
        w_tos_type_nxt = r_rdata[WIDTH+1:WIDTH];
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_tos       <= '0;
      r_tos_type  <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_pop_type  <= '0;
      r_trap      <= c_TRAP_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_tos       <= w_tos_nxt;
      r_tos_type  <= w_tos_type_nxt;
      r_pop_valid <= w_pop_valid_nxt;
      r_pop_data  <= w_pop_data_nxt;
      r_pop_type  <= w_pop_type_nxt;
      r_trap      <= w_trap_nxt;
    end
  end

  // Storage array carries no reset; liveness is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_addr] <= {r_tos_type, r_tos};
    if (w_mem_re) r_rdata <= r_mem[w_rd_addr];
  end

  assign bus.cmd_ready    = w_ready;
  assign bus.pop_valid    = r_pop_valid;
  assign bus.pop_data     = r_pop_data;
  assign bus.pop_type     = r_pop_type;
  assign bus.result       = r_tos;
  assign bus.result_type  = r_tos_type;
  assign bus.result_empty = (r_count == '0);
  assign bus.count        = r_count;
  assign bus.trap         = r_trap;
endmodule
`default_nettype wire

// File: tb/tb_operand_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_stack_ctrl
// Brief    : Directed bench with a per-cycle array-based stack model.
// Revision : 1.0
// ============================================================================
module tb_operand_stack_ctrl;
  localparam int DL = 6;
  localparam int W  = 64;
  localparam int D  = 64;
  localparam logic [1:0] I32 = 2'd0, I64 = 2'd1, F32 = 2'd2, F64 = 2'd3;
  localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  operand_stack_ctrl_if #(.DEPTH_LOG2(DL), .WIDTH(W)) bus ();
  operand_stack_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: plain stack array indexed by depth, no TOS/RAM split.
  logic [W+1:0] m_stk [0:D-1];
  int           m_cnt;
  logic [2:0]   m_trap;
  logic         m_refill, m_pv;
  logic [W+1:0] m_pval;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_trap <= 3'd0; m_refill <= 1'b0; m_pv <= 1'b0; m_pval <= '0;
    end else begin
      m_pv <= 1'b0;
      m_refill <= 1'b0;
      if (bus.cmd_valid && !m_refill && m_trap == 3'd0) begin
        if (bus.cmd_op == PUSH) begin
          if (m_cnt == D) m_trap <= 3'd2;
          else begin
            m_stk[m_cnt] <= {bus.cmd_type, bus.cmd_data};
            m_cnt <= m_cnt + 1;
          end
        end else if (bus.cmd_op == POP || bus.cmd_op == REPL) begin
          if (m_cnt == 0) m_trap <= 3'd1;
          else if (bus.chk_en && m_stk[m_cnt-1][W+1:W] != bus.chk_type) m_trap <= 3'd3;
          else begin
            m_pv   <= 1'b1;
            m_pval <= m_stk[m_cnt-1];
            if (bus.cmd_op == REPL) m_stk[m_cnt-1] <= {bus.cmd_type, bus.cmd_data};
            else begin
              m_cnt    <= m_cnt - 1;
              m_refill <= (m_cnt > 1);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("m.count", 66'(bus.count), 66'(m_cnt));
      check("m.empty", 66'(bus.result_empty), 66'(m_cnt == 0));
      check("m.trap", 66'(bus.trap), 66'(m_trap));
      check("m.ready", 66'(bus.cmd_ready), 66'(!m_refill && m_trap == 3'd0));
      check("m.pop_valid", 66'(bus.pop_valid), 66'(m_pv));
      if (m_pv) check("m.pop", {bus.pop_type, bus.pop_data}, m_pval);
      if (!m_refill)
        check("m.tos", {bus.result_type, bus.result}, (m_cnt > 0) ? m_stk[m_cnt-1] : '0);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [1:0] ty,
                        input logic ce, input logic [1:0] ct);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    bus.cmd_type = ty; bus.chk_en = ce; bus.chk_type = ct;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) begin
      tests++; fails++;
      $display("FAIL handshake: cmd_ready stayed 0, required 1");
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = NOP; bus.cmd_data = '0;
    bus.cmd_type = I32; bus.chk_en = 1'b0; bus.chk_type = I32;
    do_reset();
    check("rst.count", 66'(bus.count), 66'd0);
    check("rst.empty", 66'(bus.result_empty), 66'd1);
    check("rst.result", {bus.result_type, bus.result}, 66'd0);
    check("rst.ready", 66'(bus.cmd_ready), 66'd1);

    // 1: single push
    do_cmd(PUSH, 64'hc000000000000000, I64, 1'b0, I32);
    check("t1.tos", {bus.result_type, bus.result}, {I64, 64'hc000000000000000});
    check("t1.count", 66'(bus.count), 66'd1);
    check("t1.empty", 66'(bus.result_empty), 66'd0);

    // 2: pop with refill
    do_reset();
    do_cmd(PUSH, 64'd5, I32, 1'b0, I32);
    do_cmd(PUSH, 64'h4000000000000000, F64, 1'b0, I32);
    do_cmd(POP, 64'd0, I32, 1'b0, I32);
    check("t2.pop", {bus.pop_type, bus.pop_data}, {F64, 64'h4000000000000000});
    check("t2.pv", 66'(bus.pop_valid), 66'd1);
    check("t2.ready_refill", 66'(bus.cmd_ready), 66'd0);
    @(negedge clk);
    check("t2.tos", {bus.result_type, bus.result}, {I32, 64'd5});
    check("t2.ready", 66'(bus.cmd_ready), 66'd1);
    check("t2.pv_drop", 66'(bus.pop_valid), 66'd0);

    // 3: replace with passing type check
    do_reset();
    do_cmd(PUSH, 64'hc000000000000000, F64, 1'b0, I32);
    do_cmd(REPL, 64'hc000000000000000, I64, 1'b1, F64);
    check("t3.pop_type", 66'(bus.pop_type), 66'(F64));
    check("t3.tos_type", 66'(bus.result_type), 66'(I64));
    check("t3.count", 66'(bus.count), 66'd1);
    check("t3.ready", 66'(bus.cmd_ready), 66'd1);

    // 4: underflow
    do_reset();
    do_cmd(POP, 64'd0, I32, 1'b0, I32);
    check("t4.trap", 66'(bus.trap), 66'd1);
    check("t4.ready", 66'(bus.cmd_ready), 66'd0);
    do_reset();
    check("t4.trap_clr", 66'(bus.trap), 66'd0);

    // 5: fill, overflow, then drain in order
    for (int i = 0; i < D; i++) do_cmd(PUSH, 64'(i), I64, 1'b0, I32);
    check("t5.full", 66'(bus.count), 66'd64);
    do_cmd(PUSH, 64'd99, I64, 1'b0, I32);
    check("t5.trap", 66'(bus.trap), 66'd2);
    check("t5.tos", 66'(bus.result), 66'd63);
    do_reset();
    for (int i = 0; i < D; i++) do_cmd(PUSH, 64'(i), I64, 1'b0, I32);
    for (int k = 0; k < D; k++) begin
      do_cmd(POP, 64'd0, I32, 1'b1, I64);
      check("t5.drain", 66'(bus.pop_data), 66'(63 - k));
    end
    check("t5.empty", 66'(bus.result_empty), 66'd1);
    check("t5.drain_trap", 66'(bus.trap), 66'd0);

    // 6: type mismatch, then reset while refilling
    do_reset();
    do_cmd(PUSH, 64'd1, I32, 1'b0, I32);
    do_cmd(POP, 64'd0, I32, 1'b1, I64);
    check("t6.trap", 66'(bus.trap), 66'd3);
    check("t6.tos", {bus.result_type, bus.result}, {I32, 64'd1});
    check("t6.count", 66'(bus.count), 66'd1);
    do_reset();
    do_cmd(PUSH, 64'hab, F32, 1'b0, I32);
    do_cmd(PUSH, 64'hcd, F32, 1'b0, I32);
    do_cmd(POP, 64'd0, I32, 1'b0, I32);
    check("t6.in_refill", 66'(bus.cmd_ready), 66'd0);
    rst = 1'b1;
    #1;
    check("t6.rst_count", 66'(bus.count), 66'd0);
    check("t6.rst_empty", 66'(bus.result_empty), 66'd1);
    check("t6.rst_pv", 66'(bus.pop_valid), 66'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6.ready", 66'(bus.cmd_ready), 66'd1);
    do_cmd(NOP, 64'd0, I32, 1'b0, I32);
    check("t6.nop", 66'(bus.count), 66'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
